// File: rtl/essential_bit_sched.sv
// essential_bit_sched: walks the set bits of a weight bitmask MSB-first,
// emitting one MSB-relative index per accepted beat. Optional truncation
// after MAX_ITER beats; an all-zero mask produces a single flagged zero beat.
module essential_bit_sched #(
    parameter int W        = 8,
    parameter int IDXW     = $clog2(W),
    parameter int MAX_ITER = W,
    parameter int CNTW     = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            out_zero,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    mask_q;
    logic [W-1:0]    mask_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    logic [IDXW-1:0] hi_pos;
    logic            single_bit;
    logic            cnt_limit;
    logic            run_last;

    // Position of the highest set bit; the last match in an ascending scan wins.
    function automatic logic [IDXW-1:0] msb_pos(input logic [W-1:0] m);
        logic [IDXW-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                p = IDXW'(i);
            end
        end
        return p;
    endfunction

    // Mask with bit p removed.
    function automatic logic [W-1:0] clear_bit(input logic [W-1:0] m,
                                               input logic [IDXW-1:0] p);
        logic [W-1:0] onehot;
        onehot = {{(W-1){1'b0}}, 1'b1} << p;
        return m & ~onehot;
    endfunction

    // Priority encode of the remaining bits and last-beat detection.
    always_comb begin
        hi_pos     = msb_pos(mask_q);
        // Exactly one bit left: clearing the lowest set bit leaves nothing.
        single_bit = ((mask_q & (mask_q - {{(W-1){1'b0}}, 1'b1})) == '0);
        cnt_limit  = (cnt_q == CNTW'(MAX_ITER - 1));
        run_last   = single_bit || cnt_limit;
        mask_d     = clear_bit(mask_q, hi_pos);
        cnt_d      = cnt_q + CNTW'(1);
    end

    // Sequencer FSM: accept a mask in IDLE, serve bits in RUN, single zero beat in ZERO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mask_q  <= in_mask;
                        cnt_q   <= '0;
                        state_q <= (in_mask != '0) ? RUN : ZERO;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        cnt_q <= cnt_d;
                        if (run_last) begin
                            // Any bits beyond the truncation point are dropped here.
                            mask_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            mask_q <= mask_d;
                        end
                    end
                end
                ZERO: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only; in_ready is also held low during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = reset;
            end
            RUN: begin
                out_valid = 1'b1;
                out_idx   = IDXW'(W - 1) - hi_pos;
                out_last  = run_last;
                busy      = 1'b1;
            end
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_essential_bit_sched.sv
// Directed and table-driven bench for essential_bit_sched: one instance with
// full-length masks and one truncating after three beats.
module tb_essential_bit_sched;

    logic       clk;
    logic       reset;

    logic       in_valid, in_ready, out_valid, out_ready, out_last, out_zero, busy;
    logic [7:0] in_mask;
    logic [2:0] out_idx;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, out_last3, out_zero3, busy3;
    logic [7:0] in_mask3;
    logic [2:0] out_idx3;

    int nvec  = 0;
    int nfail = 0;

    essential_bit_sched #(.W(8), .MAX_ITER(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .out_zero(out_zero), .busy(busy)
    );

    essential_bit_sched #(.W(8), .MAX_ITER(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_mask(in_mask3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_idx(out_idx3),
        .out_last(out_last3), .out_zero(out_zero3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;
        logic [7:0] mask;
        int         n;
        logic [23:0] idxs;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Observe the outputs of the selected instance.
    task automatic peek(input int sel, output logic v, output logic [2:0] idx,
                        output logic last, output logic zero, output logic rdy);
        if (sel != 0) begin
            v = out_valid3; idx = out_idx3; last = out_last3; zero = out_zero3; rdy = in_ready3;
        end else begin
            v = out_valid; idx = out_idx; last = out_last; zero = out_zero; rdy = in_ready;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] m, input logic ordy);
        if (sel != 0) begin
            in_valid3 = v; in_mask3 = m; out_ready3 = ordy;
        end else begin
            in_valid = v; in_mask = m; out_ready = ordy;
        end
    endtask

    // Independent reference: MSB-first list of MSB-relative indices, truncated at lim.
    task automatic model(input logic [7:0] m, input int lim, output int n, output logic [23:0] idxs);
        n = 0;
        idxs = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && n < lim) begin
                idxs[3*n +: 3] = 3'(7 - i);
                n++;
            end
        end
        if (m == 8'h00) n = 1;
    endtask

    // Full transaction with out_ready held high; all comparisons done at negedge.
    task automatic xfer(input int sel, input logic [7:0] m, input int n, input logic [23:0] idxs,
                        input string tag);
        logic v, last, zero, rdy;
        logic [2:0] idx;
        logic iz;
        iz = (m == 8'h00);
        @(negedge clk);
        peek(sel, v, idx, last, zero, rdy);
        chk({tag, " in_ready_idle"}, 32'(rdy), 32'd1);
        drive(sel, 1'b1, m, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b1);
        for (int j = 0; j < n; j++) begin
            peek(sel, v, idx, last, zero, rdy);
            chk($sformatf("%s b%0d valid", tag, j), 32'(v), 32'd1);
            chk($sformatf("%s b%0d idx", tag, j), 32'(idx), iz ? 32'd0 : 32'(idxs[3*j +: 3]));
            chk($sformatf("%s b%0d last", tag, j), 32'(last), 32'(j == n - 1));
            chk($sformatf("%s b%0d zero", tag, j), 32'(zero), 32'(iz));
            chk($sformatf("%s b%0d in_ready", tag, j), 32'(rdy), 32'd0);
            @(negedge clk);
        end
        peek(sel, v, idx, last, zero, rdy);
        chk({tag, " end valid"}, 32'(v), 32'd0);
        chk({tag, " end idx"}, 32'(idx), 32'd0);
        chk({tag, " end in_ready"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        logic v, last, zero, rdy;
        logic [2:0] idx;
        logic [7:0] rm;
        int rn;
        logic [23:0] ridx;

        tbl[0] = '{0, 8'b1010_0101, 4, 24'({3'd7, 3'd5, 3'd2, 3'd0})};
        tbl[1] = '{0, 8'h00, 1, 24'd0};
        tbl[2] = '{0, 8'h80, 1, 24'({3'd0})};
        tbl[3] = '{0, 8'h01, 1, 24'({3'd7})};
        tbl[4] = '{0, 8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        tbl[5] = '{0, 8'h3C, 4, 24'({3'd5, 3'd4, 3'd3, 3'd2})};
        tbl[6] = '{1, 8'hFF, 3, 24'({3'd2, 3'd1, 3'd0})};
        tbl[7] = '{1, 8'h03, 2, 24'({3'd7, 3'd6})};
        tbl[8] = '{1, 8'h00, 1, 24'd0};

        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        chk("rst out_zero", 32'(out_zero), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 9; k++) begin
            xfer(tbl[k].sel, tbl[k].mask, tbl[k].n, tbl[k].idxs, $sformatf("tbl%0d", k));
        end

        // Backpressure on first beat of 8'b0100_0001, with stray in_valid during RUN.
        @(negedge clk);
        drive(0, 1'b1, 8'b0100_0001, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 1'b1, 8'hFF, 1'b0);
            chk($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d idx", c), 32'(out_idx), 32'd1);
            chk($sformatf("stall%0d last", c), 32'(out_last), 32'd0);
            chk($sformatf("stall%0d busy", c), 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("stall rel idx", 32'(out_idx), 32'd1);
        drive(0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("stall b1 idx", 32'(out_idx), 32'd7);
        chk("stall b1 last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("stall end valid", 32'(out_valid), 32'd0);
        chk("stall end in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-RUN discards the rest of 8'hF0.
        drive(0, 1'b1, 8'hF0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b1);
        chk("arst b0 idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        chk("arst b1 idx", 32'(out_idx), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        xfer(0, 8'h01, 1, 24'({3'd7}), "post_rst");

        // Back-to-back masks with in_valid held: one IDLE bubble between them.
        @(negedge clk);
        drive(0, 1'b1, 8'h80, 1'b1);
        @(negedge clk);
        chk("b2b m0 valid", 32'(out_valid), 32'd1);
        chk("b2b m0 idx", 32'(out_idx), 32'd0);
        chk("b2b m0 last", 32'(out_last), 32'd1);
        drive(0, 1'b1, 8'h02, 1'b1);
        @(negedge clk);
        chk("b2b bubble valid", 32'(out_valid), 32'd0);
        chk("b2b bubble in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b1);
        chk("b2b m1 valid", 32'(out_valid), 32'd1);
        chk("b2b m1 idx", 32'(out_idx), 32'd6);
        chk("b2b m1 last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("b2b end valid", 32'(out_valid), 32'd0);

        // Random masks against the reference model on both instances.
        for (int r = 0; r < 24; r++) begin
            rm = 8'($urandom_range(0, 255));
            if (r == 0) rm = 8'h00;
            model(rm, 8, rn, ridx);
            xfer(0, rm, rn, ridx, $sformatf("rnd%0d", r));
            model(rm, 3, rn, ridx);
            xfer(1, rm, rn, ridx, $sformatf("rnd3_%0d", r));
        end

        peek(0, v, idx, last, zero, rdy);
        chk("final idle", 32'(rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
